prio_grant_queue: RTL and testbench
===================================

Name: prio_grant_queue

Overview:
- Sequential request-capture and grant stage sitting directly downstream of the 4-input OR reducer in the priority-encoder path.
- Latches single-cycle request pulses into a sticky pending vector and exposes the OR of pending as `any_req`.
- Issues one grant at a time, for the highest-priority pending request (index 0 highest), over a valid/ready handshake.
- Clears each pending bit only when its grant is accepted.

Parameters:
- N, 4, number of request lines.
- IDXW, 2, grant index width; must equal clog2(N), N >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req_in  input  N  request pulses, one bit per source, sampled every clk edge.
- pending  output  N  registered sticky request vector.
- any_req  output  1  OR of all pending bits (registered-vector reduction, no extra latency).
- grant_valid  output  1  grant offered.
- grant_idx  output  IDXW  index being granted; meaningful only while grant_valid=1.
- grant_ready  input  1  consumer accepts grant.
- overflow  output  1  one-cycle pulse: a request was merged into an already-pending bit.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - pending=0, grant_valid=0, grant_idx=0, overflow=0, FSM=IDLE.
  - req_in is ignored on that edge.
  - Reset mid-grant drops the grant and all pending requests, with no handshake.
- Handshake: accept = grant_valid & grant_ready.
- Pending update, every edge: pending <= (pending & ~clr) | req_in.
  - clr = onehot(grant_idx) when accept, else 0.
  - A new request on the bit being cleared in the same cycle wins: the bit stays set (re-arm).
- Overflow: overflow <= |(req_in & pending & ~clr).
  - Registered, so it pulses one cycle after the offending edge.
  - The merged request is lost; no count is kept.
- Priority pick: lowest set bit index of the pick vector; index 0 has the highest priority. It is combinational.
- FSM states IDLE, OFFER:
  - IDLE:
    - pick vector = pending.
    - If nonzero: grant_idx <= pick, grant_valid <= 1, go to OFFER.
    - Otherwise stay in IDLE.
  - OFFER:
    - grant_valid=1. grant_idx is held stable until accept.
    - Non-preemptive: a higher-priority arrival does not change grant_idx.
  - OFFER on accept:
    - pick vector = (pending & ~clr).
    - If nonzero: load the next grant_idx and keep grant_valid=1 (back-to-back, one grant per cycle max).
    - Otherwise grant_valid <= 0 and go to IDLE.
    - req_in arriving in the accept cycle is not part of this pick; it is visible from the next cycle.
- Latency:
  - req_in high at edge t sets pending at t.
  - From IDLE, grant_valid rises at edge t+1.
  - any_req follows pending with the same timing as pending.
- grant_ready while grant_valid=0 is ignored.
- All outputs are registered except any_req, which is the OR of the pending register.

Decomposition:
- Package prio_pkg holds:
  - default N and IDXW constants;
  - FSM state type {IDLE, OFFER};
  - a function onehot(idx) returning N bits.
- One sub-module, prio_find: a parameterised combinational lowest-set-bit finder.
  - Inputs: vec[N-1:0].
  - Outputs: idx[IDXW-1:0], found.
  - Instantiated once for the pick vector.
- The any_req reduction reuses the existing or4 block when N=4 and is inline otherwise.

Test Plan:
- Reset:
  - Stimulus: hold rst=1 for 2 edges with req_in=4'b1111.
  - Response: pending=0, any_req=0, grant_valid=0, overflow=0 after the first reset edge.
- Single request:
  - Stimulus: req_in=4'b0100 for 1 cycle; grant_ready=1.
  - Response: pending=0100 and any_req=1 after edge t; grant_valid=1 with grant_idx=2 after t+1; pending=0 and grant_valid=0 after t+2.
- Priority and non-preemption:
  - Stimulus: req_in=4'b1010 with grant_ready=0; after the grant appears, pulse req_in=4'b0001.
  - Response: grant_idx=1 stays held; pending=1011.
  - Stimulus: then grant_ready=1.
  - Response: grant order is idx 1, 0, 3 on consecutive cycles.
- Overflow and re-arm:
  - Stimulus: with pending bit 3 set and no accept, pulse req_in[3].
  - Response: overflow=1 for exactly one cycle; pending[3] stays 1.
  - Stimulus: pulse req_in[3] in the same cycle as accept of idx 3.
  - Response: pending[3]=1 afterwards, and overflow stays 0.
- Back-to-back throughput:
  - Stimulus: req_in=4'b1111 once, grant_ready held 1.
  - Response: grant_valid high for 4 consecutive cycles with idx 0, 1, 2, 3, then 0; any_req falls in the same cycle.
- Reset mid-operation:
  - Stimulus: grant_valid=1 with idx=0 and pending=0111; assert rst for 1 edge.
  - Response: all outputs 0 next cycle; no grant is issued until a new req_in.

Source files
------------

// File: rtl/prio_grant_queue_pkg.sv
// Shared types and helpers for the priority grant queue.
// Default sizing, grant FSM state type and a one-hot decoder.
package prio_pkg;
    localparam int N_DEF    = 4;
    localparam int IDXW_DEF = 2;
    localparam int MAX_N    = 32;

    typedef enum logic {IDLE, OFFER} state_t;

    // Callers truncate the result to their own request width.
    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
        return MAX_N'(1) << idx;
    endfunction
endpackage

// File: rtl/prio_grant_queue_if.sv
// Request/grant bundle between request sources, the grant queue and the grant consumer.
// slave is the queue side; master drives requests and grant_ready.
interface prio_grant_queue_if #(
    parameter int N    = prio_pkg::N_DEF,
    parameter int IDXW = prio_pkg::IDXW_DEF
);
    logic [N-1:0]    req_in;
    logic [N-1:0]    pending;
    logic            any_req;
    logic            grant_valid;
    logic [IDXW-1:0] grant_idx;
    logic            grant_ready;
    logic            overflow;

    modport master (
        output req_in, grant_ready,
        input  pending, any_req, grant_valid, grant_idx, overflow
    );

    modport slave (
        input  req_in, grant_ready,
        output pending, any_req, grant_valid, grant_idx, overflow
    );
endinterface

// File: rtl/or4.sv
// 4-input OR reducer from the priority-encoder path.
// Purely combinational, no latency, no backpressure.
module or4 (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic y
);
    assign y = a | b | c | d;
endmodule

// File: rtl/prio_grant_queue_find.sv
// Lowest-set-bit finder: idx of the lowest set bit of vec, found when vec is nonzero.
// Combinational, zero latency, no backpressure.
module prio_find #(
    parameter int N    = prio_pkg::N_DEF,
    parameter int IDXW = prio_pkg::IDXW_DEF
) (
    input  logic [N-1:0]    vec,
    output logic [IDXW-1:0] idx,
    output logic            found
);
    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Walk downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDXW'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/prio_grant_queue.sv
// Sticky request capture with one-at-a-time, non-preemptive lowest-index grant over valid/ready.
// Request visible in pending one edge after the pulse, grant one edge later; grant held until ready.
module prio_grant_queue
    import prio_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int IDXW = IDXW_DEF
) (
    input logic              clk,
    input logic              rst,
    prio_grant_queue_if.slave bus
);
    state_t          state_q, state_d;
    logic [N-1:0]    pending_q, pending_d;
    logic            grant_valid_q, grant_valid_d;
    logic [IDXW-1:0] grant_idx_q, grant_idx_d;
    logic            overflow_q, overflow_d;

    logic            accept;
    logic [N-1:0]    clr;
    logic [N-1:0]    pick_vec;
    logic [IDXW-1:0] pick_idx;
    logic            pick_found;
    logic            any_req;

    assign accept = grant_valid_q & bus.grant_ready;
    assign clr    = accept ? N'(onehot(32'(grant_idx_q))) : '0;

    // Requests arriving in the accept cycle are deliberately excluded from the next pick.
    assign pick_vec = (state_q == IDLE) ? pending_q : (pending_q & ~clr);

    prio_find #(.N(N), .IDXW(IDXW)) u_find (
        .vec   (pick_vec),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        pending_d     = (pending_q & ~clr) | bus.req_in;
        overflow_d    = |(bus.req_in & pending_q & ~clr);
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_idx_d   = grant_idx_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_idx_d   = pick_idx;
                    grant_valid_d = 1'b1;
                    state_d       = OFFER;
                end
            end
            OFFER: begin
                if (accept) begin
                    if (pick_found) begin
                        grant_idx_d = pick_idx;
                    end else begin
                        grant_valid_d = 1'b0;
                        state_d       = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            overflow_q    <= overflow_d;
        end
    end

    generate
        if (N == 4) begin : g_or4
            or4 u_or4 (
                .a (pending_q[0]),
                .b (pending_q[1]),
                .c (pending_q[2]),
                .d (pending_q[3]),
                .y (any_req)
            );
        end else begin : g_or_inline
            assign any_req = |pending_q;
        end
    endgenerate

    assign bus.pending     = pending_q;
    assign bus.any_req     = any_req;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_idx   = grant_idx_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_prio_grant_queue.sv
// Directed plus random stimulus for prio_grant_queue, checked every cycle against a
// request-set / current-offer reference model.
module tb_prio_grant_queue;
    logic clk;
    logic rst;

    prio_grant_queue_if #(.N(4), .IDXW(2)) bus ();

    prio_grant_queue #(.N(4), .IDXW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: set of outstanding requests, index currently offered (-1 = none).
    bit [3:0] m_pend;
    int       m_offer;
    int       m_idx;
    bit       m_ovf;
    int       order_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input bit [3:0] v, input int skip);
        for (int i = 0; i < 4; i++)
            if (v[i] && i != skip) return i;
        return -1;
    endfunction

    task automatic model_update(input logic [3:0] r, input logic rdy, input logic rs);
        bit [3:0] old;
        int       served;
        if (rs) begin
            m_pend  = '0;
            m_offer = -1;
            m_idx   = 0;
            m_ovf   = 1'b0;
            return;
        end
        old    = m_pend;
        served = (m_offer >= 0 && rdy) ? m_offer : -1;
        if (served >= 0) order_q.push_back(served);
        m_ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (r[i] && old[i] && i != served) m_ovf = 1'b1;
            m_pend[i] = (old[i] && i != served) || r[i];
        end
        if (m_offer < 0)       m_offer = lowest(old, -1);
        else if (served >= 0)  m_offer = lowest(old, served);
        if (m_offer >= 0) m_idx = m_offer;
    endtask

    task automatic check_all();
        chk("pending",     32'(bus.pending),     32'(m_pend));
        chk("any_req",     32'(bus.any_req),     32'(|m_pend));
        chk("grant_valid", 32'(bus.grant_valid), 32'(m_offer >= 0));
        chk("overflow",    32'(bus.overflow),    32'(m_ovf));
        if (m_offer >= 0) chk("grant_idx", 32'(bus.grant_idx), 32'(m_idx));
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
    task automatic step(input logic [3:0] r, input logic rdy, input logic rs);
        bus.req_in      = r;
        bus.grant_ready = rdy;
        rst             = rs;
        @(posedge clk);
        #1;
        model_update(r, rdy, rs);
        check_all();
    endtask

    initial begin
        logic [3:0] r;
        logic       rdy;
        logic       rs;
        m_pend  = '0;
        m_offer = -1;
        m_idx   = 0;
        m_ovf   = 1'b0;
        rst             = 1'b1;
        bus.req_in      = '0;
        bus.grant_ready = 1'b0;
        #2;

        // Reset with all requests asserted.
        step(4'b1111, 1'b0, 1'b1);
        chk("rst_pending", 32'(bus.pending), 32'h0);
        chk("rst_idx", 32'(bus.grant_idx), 32'h0);
        step(4'b1111, 1'b0, 1'b1);

        // Single request.
        step(4'b0100, 1'b1, 1'b0);
        chk("single_any_t", 32'(bus.any_req), 32'h1);
        step(4'b0000, 1'b1, 1'b0);
        chk("single_idx", 32'(bus.grant_idx), 32'h2);
        step(4'b0000, 1'b1, 1'b0);
        chk("single_done_valid", 32'(bus.grant_valid), 32'h0);

        // Priority and non-preemption.
        order_q.delete();
        step(4'b1010, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        chk("nonpreempt_idx", 32'(bus.grant_idx), 32'h1);
        chk("nonpreempt_pend", 32'(bus.pending), 32'hb);
        repeat (3) step(4'b0000, 1'b1, 1'b0);
        chk("order_len", 32'(order_q.size()), 32'd3);
        if (order_q.size() == 3) begin
            chk("order_0", 32'(order_q[0]), 32'd1);
            chk("order_1", 32'(order_q[1]), 32'd0);
            chk("order_2", 32'(order_q[2]), 32'd3);
        end

        // Overflow, then re-arm on the accept cycle.
        step(4'b1000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        chk("ovf_pulse", 32'(bus.overflow), 32'h1);
        step(4'b0000, 1'b0, 1'b0);
        chk("ovf_gone", 32'(bus.overflow), 32'h0);
        step(4'b1000, 1'b1, 1'b0);
        chk("rearm_pend", 32'(bus.pending), 32'h8);
        chk("rearm_no_ovf", 32'(bus.overflow), 32'h0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);

        // Back-to-back throughput.
        order_q.delete();
        step(4'b1111, 1'b1, 1'b0);
        repeat (5) step(4'b0000, 1'b1, 1'b0);
        chk("b2b_len", 32'(order_q.size()), 32'd4);
        for (int i = 0; i < order_q.size(); i++) chk("b2b_order", 32'(order_q[i]), 32'(i));
        chk("b2b_any_low", 32'(bus.any_req), 32'h0);

        // Reset while a grant is offered.
        step(4'b0111, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        chk("mid_idx", 32'(bus.grant_idx), 32'h0);
        step(4'b0000, 1'b1, 1'b1);
        chk("mid_rst_valid", 32'(bus.grant_valid), 32'h0);
        repeat (3) step(4'b0000, 1'b1, 1'b0);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            r   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            rdy = 1'($urandom_range(0, 1));
            rs  = ($urandom_range(0, 59) == 0);
            step(r, rdy, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
